// File: rtl/int_sync_crossing_sink.sv
// Sink end of an interrupt clock-domain crossing.
// Each interrupt line passes through a multi-flop synchroniser and an optional
// per-bit debounce filter. Sticky pending/overrun flags record rising edges of
// the filtered level and can be cleared per bit with clr.
module int_sync_crossing_sink #(
    parameter int unsigned WIDTH  = 2,
    parameter int unsigned SYNC   = 3,
    parameter int unsigned FILTER = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] auto_in_sync,
    output logic [WIDTH-1:0] auto_out,
    output logic [WIDTH-1:0] pending,
    output logic [WIDTH-1:0] overrun,
    input  logic [WIDTH-1:0] clr
);

    // With FILTER=0 the counters are kept at a nominal width of one bit and
    // are never advanced.
    localparam int unsigned      CW       = (FILTER > 0) ? $clog2(FILTER + 1) : 1;
    localparam int unsigned      LAST_INT = (FILTER > 0) ? FILTER - 1 : 0;
    localparam logic [CW-1:0]    CNT_LAST = CW'(LAST_INT);

    logic [WIDTH-1:0] stage [SYNC];
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_next [WIDTH];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_next;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] pending_next;
    logic [WIDTH-1:0] overrun_next;

    assign s        = stage[SYNC-1];
    assign auto_out = out_q;

    // Next filtered level and debounce counters; without a filter the output
    // register simply tracks the last synchroniser stage, so it equals s.
    always_comb begin
        out_next = out_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
        end
        if (FILTER == 0) begin
            out_next = stage[SYNC-2];
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (s[i] == out_q[i]) begin
                    cnt_next[i] = '0;
                end else if (cnt[i] == CNT_LAST) begin
                    out_next[i] = s[i];
                    cnt_next[i] = '0;
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Rising edge is taken from the next-state level so pending sets on the
    // same edge auto_out rises; a set beats a simultaneous clear, but clr
    // always wipes overrun.
    always_comb begin
        rise         = out_next & ~out_q;
        pending_next = rise | (pending & ~clr);
        overrun_next = ~clr & (overrun | (rise & pending));
    end

    // State registers: synchroniser chain, counters, level and sticky flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned k = 0; k < SYNC; k++) begin
                stage[k] <= '0;
            end
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            out_q   <= '0;
            pending <= '0;
            overrun <= '0;
        end else begin
            stage[0] <= auto_in_sync;
            for (int unsigned k = 1; k < SYNC; k++) begin
                stage[k] <= stage[k-1];
            end
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
            out_q   <= out_next;
            pending <= pending_next;
            overrun <= overrun_next;
        end
    end

endmodule

// File: tb/tb_int_sync_crossing_sink.sv
// Directed bench: one unfiltered (FILTER=0) and one debounced (FILTER=4)
// instance, both WIDTH=2, SYNC=3, sharing clock and reset.
module tb_int_sync_crossing_sink;

    logic       clock;
    logic       reset;
    logic [1:0] in0, clr0, out0, pend0, ovr0;
    logic [1:0] in4, clr4, out4, pend4, ovr4;

    int n_checks = 0;
    int n_fail   = 0;

    int_sync_crossing_sink #(.WIDTH(2), .SYNC(3), .FILTER(0)) dut0 (
        .clock        (clock),
        .reset        (reset),
        .auto_in_sync (in0),
        .auto_out     (out0),
        .pending      (pend0),
        .overrun      (ovr0),
        .clr          (clr0)
    );

    int_sync_crossing_sink #(.WIDTH(2), .SYNC(3), .FILTER(4)) dut4 (
        .clock        (clock),
        .reset        (reset),
        .auto_in_sync (in4),
        .auto_out     (out4),
        .pending      (pend4),
        .overrun      (ovr4),
        .clr          (clr4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        in0 = '0; clr0 = '0; in4 = '0; clr4 = '0;

        // 1: reset then idle
        tick(2);
        check("rst_out0", 8'(out0), 8'h0);
        check("rst_pend0", 8'(pend0), 8'h0);
        check("rst_ovr0", 8'(ovr0), 8'h0);
        check("rst_out4", 8'(out4), 8'h0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_out0", 8'(out0), 8'h0);
            check("idle_pend0", 8'(pend0), 8'h0);
            check("idle_ovr0", 8'(ovr0), 8'h0);
        end

        // 2: latency with no filter
        in0 = 2'b01;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("lat_out0", 8'(out0), (i == 3) ? 8'h1 : 8'h0);
            check("lat_pend0", 8'(pend0), (i == 3) ? 8'h1 : 8'h0);
        end

        // 4: overrun on a second rise without clear
        in0 = 2'b00;
        tick(3);
        check("drop_out0", 8'(out0), 8'h0);
        check("drop_pend0", 8'(pend0), 8'h1);
        in0 = 2'b01;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("ovr_ovr0", 8'(ovr0), (i == 3) ? 8'h1 : 8'h0);
        end
        check("ovr_out0", 8'(out0), 8'h1);
        clr0 = 2'b01;
        tick();
        clr0 = 2'b00;
        check("clr_pend0", 8'(pend0), 8'h0);
        check("clr_ovr0", 8'(ovr0), 8'h0);
        check("clr_out0", 8'(out0), 8'h1);

        // 5: clr coincident with a rise while pending is set
        in0 = 2'b00;
        tick(3);
        in0 = 2'b01;
        tick(3);
        check("rise2_pend0", 8'(pend0), 8'h1);
        check("rise2_ovr0", 8'(ovr0), 8'h0);
        in0 = 2'b00;
        tick(3);
        in0 = 2'b01;
        tick(2);
        clr0 = 2'b01;
        tick();
        clr0 = 2'b00;
        check("setclr_out0", 8'(out0), 8'h1);
        check("setclr_pend0", 8'(pend0), 8'h1);
        check("setclr_ovr0", 8'(ovr0), 8'h0);

        // 3: debounce, a 3-cycle pulse is discarded
        in4 = 2'b10;
        tick(3);
        in4 = 2'b00;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("glitch_out4", 8'(out4), 8'h0);
            check("glitch_pend4", 8'(pend4), 8'h0);
        end
        in4 = 2'b10;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("deb_rise_out4", 8'(out4), (i == 7) ? 8'h2 : 8'h0);
        end
        check("deb_rise_pend4", 8'(pend4), 8'h2);
        in4 = 2'b00;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("deb_fall_out4", 8'(out4), (i == 7) ? 8'h0 : 8'h2);
        end
        check("deb_fall_pend4", 8'(pend4), 8'h2);

        // 6: reset mid-operation with a counter part-way
        in4 = 2'b11;
        tick(7);
        check("pre_out4", 8'(out4), 8'h3);
        check("pre_pend4", 8'(pend4), 8'h3);
        check("pre_ovr4", 8'(ovr4), 8'h2);
        in4 = 2'b00;
        tick(5);
        check("mid_out4", 8'(out4), 8'h3);
        reset = 1'b1;
        tick();
        check("mrst_out4", 8'(out4), 8'h0);
        check("mrst_pend4", 8'(pend4), 8'h0);
        check("mrst_ovr4", 8'(ovr4), 8'h0);
        check("mrst_out0", 8'(out0), 8'h0);
        check("mrst_pend0", 8'(pend0), 8'h0);
        reset = 1'b0;
        in4 = 2'b11;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("post_out4", 8'(out4), (i == 7) ? 8'h3 : 8'h0);
        end
        check("post_pend4", 8'(pend4), 8'h3);
        check("post_ovr4", 8'(ovr4), 8'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
